cache_refill_ctrl: RTL and testbench



---
 rtl/refill_pkg.sv | 17 +
 rtl/refill_watchdog.sv | 29 ++
 rtl/cache_refill_ctrl.sv | 123 ++++++++++++
 tb/tb_cache_refill_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// Shared constants, state encoding and field widths for the cache line-fill controller.
package refill_pkg;

  localparam int BLOCK_WIDTH    = 8;
  localparam int OFFSET_BITS    = 3;
  localparam int INDEX_BITS     = 6;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int TAG_BITS       = 32 - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    GAP  = 2'd3
  } refill_state_t;

endpackage

// File: rtl/refill_watchdog.sv
// Idle-cycle watchdog: counts while running, restarts on every beat, flags expiry.
module refill_watchdog
  import refill_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic rst,
  input  logic run,
  input  logic beat,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (rst || !run || beat) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  // Fires on the LIMIT-th consecutive beat-free cycle so the abort lands LIMIT cycles after the request.
  assign expired = run && !beat && (count == W'(LIMIT - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Line-fill initiator: one block read per miss, writes beats into the data RAM,
// validates the tag on the last beat, forwards the critical word, aborts on DRAM timeout.
module cache_refill_ctrl
  import refill_pkg::*;
(
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [31:0]            miss_address,
  output logic                   refill_busy,
  output logic                   refill_done,
  output logic                   refill_err,
  output logic                   crit_vld,
  output logic [31:0]            crit_data,
  output logic                   dram_rd_req,
  output logic [31:0]            dram_rd_address,
  input  logic                   dram_rd_vld,
  input  logic [31:0]            dram_rd_data,
  output logic                   line_wr_en,
  output logic [INDEX_BITS-1:0]  line_wr_index,
  output logic [OFFSET_BITS-1:0] line_wr_word,
  output logic [31:0]            line_wr_data,
  output logic                   tag_wr_en,
  output logic [TAG_BITS-1:0]    tag_wr_tag,
  output logic [1:0]             dbg_state
);

  refill_state_t          state, state_n;
  logic [31:0]            addr_q;
  logic [OFFSET_BITS-1:0] beat_cnt;
  logic                   active, beat, last_beat, expired, accept, is_crit;

  // Handshake: dram_rd_req is a level held from REQ through FILL; each cycle with
  // dram_rd_vld=1 in those states is one beat, consumed unconditionally (no back-pressure).
  assign active    = (state == REQ) || (state == FILL);
  assign beat      = active && dram_rd_vld;
  assign last_beat = beat && (beat_cnt == OFFSET_BITS'(BLOCK_WIDTH - 1));
  assign is_crit   = (beat_cnt == addr_q[OFFSET_BITS-1:0]);

  refill_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .rst     (rst),
    .run     (active),
    .beat    (beat),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) begin
          state_n = REQ;
          accept  = 1'b1;
        end
      end
      REQ, FILL: begin
        if (last_beat) begin
          state_n = GAP;
        end else if (beat) begin
          state_n = FILL;
        end else if (expired) begin
          state_n = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      addr_q       <= '0;
      beat_cnt     <= '0;
      line_wr_en   <= 1'b0;
      line_wr_word <= '0;
      line_wr_data <= '0;
      crit_vld     <= 1'b0;
      crit_data    <= '0;
      tag_wr_en    <= 1'b0;
      tag_wr_tag   <= '0;
      refill_done  <= 1'b0;
      refill_err   <= 1'b0;
    end else begin
      line_wr_en  <= beat;
      crit_vld    <= beat && is_crit;
      tag_wr_en   <= last_beat;
      refill_done <= last_beat;
      refill_err  <= expired;
      if (accept) begin
        addr_q   <= miss_address;
        beat_cnt <= '0;
      end
      if (beat) begin
        line_wr_word <= beat_cnt;
        line_wr_data <= dram_rd_data;
        beat_cnt     <= beat_cnt + OFFSET_BITS'(1);
        if (is_crit) begin
          crit_data <= dram_rd_data;
        end
      end
      if (last_beat) begin
        tag_wr_tag <= addr_q[31:OFFSET_BITS+INDEX_BITS];
      end
    end
  end

  assign dram_rd_req     = active;
  assign dram_rd_address = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign line_wr_index   = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign refill_busy     = (state != IDLE);
  assign dbg_state       = state;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: DRAM responder model, write scoreboard, vector table and corner sequences.
module tb_cache_refill_ctrl;
  import refill_pkg::*;

  logic                   clock, rst, miss_req;
  logic [31:0]            miss_address;
  logic                   refill_busy, refill_done, refill_err, crit_vld;
  logic [31:0]            crit_data;
  logic                   dram_rd_req;
  logic [31:0]            dram_rd_address;
  logic                   dram_rd_vld;
  logic [31:0]            dram_rd_data;
  logic                   line_wr_en;
  logic [INDEX_BITS-1:0]  line_wr_index;
  logic [OFFSET_BITS-1:0] line_wr_word;
  logic [31:0]            line_wr_data;
  logic                   tag_wr_en;
  logic [TAG_BITS-1:0]    tag_wr_tag;
  logic [1:0]             dbg_state;

  logic        resp_vld, spur_vld, dram_en;
  logic [31:0] resp_data, spur_data;

  assign dram_rd_vld  = resp_vld | spur_vld;
  assign dram_rd_data = resp_vld ? resp_data : spur_data;

  cache_refill_ctrl dut (
    .clock           (clock),
    .rst             (rst),
    .miss_req        (miss_req),
    .miss_address    (miss_address),
    .refill_busy     (refill_busy),
    .refill_done     (refill_done),
    .refill_err      (refill_err),
    .crit_vld        (crit_vld),
    .crit_data       (crit_data),
    .dram_rd_req     (dram_rd_req),
    .dram_rd_address (dram_rd_address),
    .dram_rd_vld     (dram_rd_vld),
    .dram_rd_data    (dram_rd_data),
    .line_wr_en      (line_wr_en),
    .line_wr_index   (line_wr_index),
    .line_wr_word    (line_wr_word),
    .line_wr_data    (line_wr_data),
    .tag_wr_en       (tag_wr_en),
    .tag_wr_tag      (tag_wr_tag),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0]            addr;
    bit                     stall;
    logic [31:0]            exp_rd_addr;
    logic [INDEX_BITS-1:0]  exp_index;
    logic [TAG_BITS-1:0]    exp_tag;
    logic [OFFSET_BITS-1:0] exp_crit;
  } vec_t;

  vec_t vecs[6];

  logic [OFFSET_BITS+31:0] exp_q[$];
  logic [31:0]             cur_rd_addr;
  logic [INDEX_BITS-1:0]   cur_index;
  logic [TAG_BITS-1:0]     cur_tag;
  logic [OFFSET_BITS-1:0]  cur_crit;

  int checks, errors;
  int n_wr, n_done, n_err, n_tag, n_crit;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // DRAM responder: one block of 8 beats per rising request, random spacing
  initial begin
    logic [31:0] base;
    resp_vld  = 1'b0;
    resp_data = '0;
    forever begin
      @(negedge clock);
      if (dram_rd_req && dram_en && !rst) begin
        base = dram_rd_address;
        for (int b = 0; b < BLOCK_WIDTH; b++) begin
          repeat ($urandom_range(1, 5)) @(negedge clock);
          if (!dram_rd_req || rst) break;
          resp_vld  = 1'b1;
          resp_data = mem_word(base + 32'(b));
          exp_q.push_back({OFFSET_BITS'(b), resp_data});
          @(negedge clock);
          resp_vld = 1'b0;
        end
        while (dram_rd_req) @(negedge clock);
      end
    end
  end

  // scoreboard / monitor
  initial begin
    logic [OFFSET_BITS+31:0] e;
    forever begin
      @(negedge clock);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (line_wr_en) begin
          n_wr++;
          chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_word", 32'(line_wr_word), 32'(e[OFFSET_BITS+31:32]));
            chk("wr_data", line_wr_data, e[31:0]);
            chk("wr_index", 32'(line_wr_index), 32'(cur_index));
          end
        end
        if (crit_vld) begin
          n_crit++;
          chk("crit_word", 32'(line_wr_word), 32'(cur_crit));
          chk("crit_data", crit_data, mem_word(cur_rd_addr + 32'(cur_crit)));
          chk("crit_with_wr", 32'(line_wr_en), 32'd1);
          chk("crit_done_align", 32'(refill_done), 32'(cur_crit == OFFSET_BITS'(BLOCK_WIDTH - 1)));
        end
        if (tag_wr_en) begin
          n_tag++;
          chk("tag_value", 32'(tag_wr_tag), 32'(cur_tag));
          chk("tag_with_done", 32'(refill_done), 32'd1);
        end
        if (refill_done) n_done++;
        if (refill_err) n_err++;
      end
    end
  end

  task automatic set_cur(input int i);
    cur_rd_addr = vecs[i].exp_rd_addr;
    cur_index   = vecs[i].exp_index;
    cur_tag     = vecs[i].exp_tag;
    cur_crit    = vecs[i].exp_crit;
    dram_en     = !vecs[i].stall;
  endtask

  // entered on a negedge with the controller in IDLE
  task automatic do_refill(input int i, input bit hold, input logic [31:0] next_addr);
    int wr0, done0, err0, tag0, crit0, lat;
    bit st;
    st = vecs[i].stall;
    set_cur(i);
    wr0 = n_wr; done0 = n_done; err0 = n_err; tag0 = n_tag; crit0 = n_crit;
    miss_req     = 1'b1;
    miss_address = vecs[i].addr;
    @(negedge clock);
    chk("req_rise", 32'(dram_rd_req), 32'd1);
    chk("rd_addr", dram_rd_address, vecs[i].exp_rd_addr);
    chk("busy_on", 32'(refill_busy), 32'd1);
    lat = 0;
    while (!(refill_done || refill_err) && lat < 400) begin
      @(negedge clock);
      lat++;
    end
    chk("fill_end_seen", 32'(refill_done | refill_err), 32'd1);
    if (st) chk("timeout_latency", 32'(lat), 32'(TIMEOUT_CYCLES));
    chk("done_pulse", 32'(refill_done), 32'(!st));
    chk("err_pulse", 32'(refill_err), 32'(st));
    chk("req_low_gap", 32'(dram_rd_req), 32'd0);
    chk("busy_gap", 32'(refill_busy), 32'd1);
    chk("state_gap", 32'(dbg_state), 32'(GAP));
    if (hold) miss_address = next_addr;
    else miss_req = 1'b0;
    @(negedge clock);
    chk("state_idle", 32'(dbg_state), 32'(IDLE));
    chk("busy_idle", 32'(refill_busy), 32'd0);
    chk("req_low_idle", 32'(dram_rd_req), 32'd0);
    chk("n_writes", 32'(n_wr - wr0), st ? 32'd0 : 32'(BLOCK_WIDTH));
    chk("n_done", 32'(n_done - done0), 32'(!st));
    chk("n_err", 32'(n_err - err0), 32'(st));
    chk("n_tag", 32'(n_tag - tag0), 32'(!st));
    chk("n_crit", 32'(n_crit - crit0), 32'(!st));
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset_mid_fill();
    int wr0, done0, err0, tag0, lat;
    set_cur(0);
    wr0 = n_wr; done0 = n_done; err0 = n_err; tag0 = n_tag;
    miss_req     = 1'b1;
    miss_address = vecs[0].addr;
    lat = 0;
    while ((n_wr - wr0) < 4 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk("beats_before_rst", 32'(n_wr - wr0), 32'd4);
    rst      = 1'b1;
    miss_req = 1'b0;
    @(negedge clock);
    chk("rst_req", 32'(dram_rd_req), 32'd0);
    chk("rst_busy", 32'(refill_busy), 32'd0);
    chk("rst_wr_en", 32'(line_wr_en), 32'd0);
    chk("rst_wr_data", line_wr_data, 32'd0);
    chk("rst_crit", 32'(crit_vld), 32'd0);
    chk("rst_done_err", 32'({refill_done, refill_err, tag_wr_en}), 32'd0);
    chk("rst_rd_addr", dram_rd_address, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clock);
    rst = 1'b0;
    repeat (10) @(negedge clock);
    chk("rst_no_done", 32'(n_done - done0), 32'd0);
    chk("rst_no_err", 32'(n_err - err0), 32'd0);
    chk("rst_no_tag", 32'(n_tag - tag0), 32'd0);
    chk("rst_idle_after", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_spurious();
    int wr0;
    wr0 = n_wr;
    for (int k = 0; k < 3; k++) begin
      spur_vld  = 1'b1;
      spur_data = 32'hBAD0_0000 + 32'($urandom_range(0, 255));
      @(negedge clock);
      chk("spur_state", 32'(dbg_state), 32'(IDLE));
    end
    spur_vld = 1'b0;
    repeat (3) @(negedge clock);
    chk("spur_no_write", 32'(n_wr - wr0), 32'd0);
    chk("spur_busy", 32'(refill_busy), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    n_wr = 0; n_done = 0; n_err = 0; n_tag = 0; n_crit = 0;
    rst = 1'b1; miss_req = 1'b0; miss_address = '0;
    spur_vld = 1'b0; spur_data = '0; dram_en = 1'b1;
    cur_rd_addr = '0; cur_index = '0; cur_tag = '0; cur_crit = '0;

    vecs[0] = '{32'h0000_1234, 1'b0, 32'h0000_1230, 6'h06, 23'h000009, 3'd4};
    vecs[1] = '{32'h0000_1230, 1'b0, 32'h0000_1230, 6'h06, 23'h000009, 3'd0};
    vecs[2] = '{32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEE8, 6'h1D, 23'h6F56DF, 3'd7};
    vecs[3] = '{32'h0000_01FF, 1'b0, 32'h0000_01F8, 6'h3F, 23'h000000, 3'd7};
    vecs[4] = '{32'h0000_4444, 1'b1, 32'h0000_4440, 6'h08, 23'h000022, 3'd4};
    vecs[5] = '{32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFF8, 6'h3F, 23'h7FFFFF, 3'd2};

    repeat (3) @(negedge clock);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_outputs", 32'({refill_busy, refill_done, refill_err, crit_vld, dram_rd_req,
                              line_wr_en, tag_wr_en}), 32'd0);
    chk("reset_rd_addr", dram_rd_address, 32'd0);
    rst = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      do_refill(i, 1'b0, 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // back-to-back: requester keeps miss_req high across the GAP/IDLE boundary
    do_refill(0, 1'b1, vecs[2].addr);
    do_refill(2, 1'b0, 32'd0);

    do_reset_mid_fill();
    do_refill(0, 1'b0, 32'd0);

    do_spurious();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
